// File: rtl/enc_pkg.sv
// Shared constants and helpers for the priority event encoder.
// No logic; compile-time only.
// Imported by prio_enc_core and prio_event_encoder.
//
// Contents:
//   PRIO_MSB / PRIO_LSB  values for the MSB_FIRST parameter
//   safe_clog2(n)        index width, never less than 1 bit
package enc_pkg;

   localparam int PRIO_MSB = 1;
   localparam int PRIO_LSB = 0;

   // A 1-line encoder still needs a 1-bit index port.
   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational N-to-log2(N) priority encoder, direction set by MSB_FIRST.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; follows vec every cycle.
//
// Ports:
//   vec  in   N  request vector
//   idx  out  W  index of the winning set bit (0 when vec is all zero)
//   any  out  1  at least one bit of vec is set
module prio_enc_core
   import enc_pkg::*;
#(
   parameter int N         = 8,
   parameter int MSB_FIRST = PRIO_MSB,
   localparam int W        = safe_clog2(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         any
);

   // The last matching bit visited by the loop wins, so the scan direction
   // is the reverse of the priority direction.
   always_comb begin
      idx = '0;
      any = |vec;
      if (MSB_FIRST != PRIO_LSB) begin
         for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = i[W-1:0];
         end
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = i[W-1:0];
         end
      end
   end

endmodule

// File: rtl/prio_event_encoder.sv
// Sticky event capture with one prioritised index issued per cycle on valid/ready.
// Latency: req at edge t with an empty slot -> out_valid at t+1; 1 index/cycle when out_ready.
// Backpressure: out_valid/out_idx hold while !out_ready; requests keep accumulating in pending.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous reset, active-high
//   req        in   N  request lines, OR'd into pending every cycle
//   out_ready  in   1  consumer accepts out_idx this cycle
//   clr_ovf    in   1  clears overflow (a coincident new overflow wins)
//   out_valid  out  1  out_idx holds an issued event
//   out_idx    out  W  encoded index of the issued event
//   pending    out  N  pending events, excluding the one in the output slot
//   overflow   out  1  sticky: a request arrived for a bit already pending
module prio_event_encoder
   import enc_pkg::*;
#(
   parameter int N         = 8,
   parameter int MSB_FIRST = PRIO_MSB,
   localparam int W        = safe_clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         out_ready,
   input  logic         clr_ovf,
   output logic         out_valid,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] pending,
   output logic         overflow
);

   logic [N-1:0] pend_in;
   logic [N-1:0] sel_onehot;
   logic [W-1:0] sel_idx;
   logic         sel_any;
   logic         take;
   logic         hit;

   // Requests arriving this cycle compete alongside older pending bits, so an
   // accept and a new request in the same cycle cause no bubble.
   assign pend_in    = pending | req;
   assign take       = !out_valid || out_ready;
   assign sel_onehot = N'(1) << sel_idx;

   // Compared against registered pending only: a request for the index sitting
   // in the output slot is a fresh event, not a lost one.
   assign hit = |(req & pending);

   prio_enc_core #(
      .N         (N),
      .MSB_FIRST (MSB_FIRST)
   ) u_core (
      .vec (pend_in),
      .idx (sel_idx),
      .any (sel_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= '0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         overflow  <= 1'b0;
      end else begin
         if (take && sel_any) begin
            // Winning bit moves from pending into the output slot.
            out_valid <= 1'b1;
            out_idx   <= sel_idx;
            pending   <= pend_in & ~sel_onehot;
         end else begin
            if (take) out_valid <= 1'b0;
            pending <= pend_in;
         end

         if (hit)          overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

endmodule
